store_drain_buffer: RTL

- In-order buffer of committed stores that sits between the LSU commit path and the data memory store channel.
- Accepts committed stores, drains them to dmem one at a time, and pops an entry only when dmem returns store completion.
- Provides combinational byte-wise store-to-load forwarding so the LSU can bypass dmem loads or stall them.

---
 rtl/store_drain_buffer_pkg.sv | 17 +
 rtl/store_drain_buffer_if.sv | 45 ++++
 rtl/store_drain_buffer_fwd_merge.sv | 43 ++++
 rtl/store_drain_buffer.sv | 114 +++++++++++
 4 files changed

// File: rtl/store_drain_buffer_pkg.sv
// Shared LSU types for the store drain buffer: the buffered store entry and
// the dmem issue state machine encoding.
package lsu_pkg;

    typedef struct packed {
        logic [31:3] addr;
        logic [63:0] data;
        logic [7:0]  wstrb;
    } sb_entry_t;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_REQ  = 2'd1,
        SB_WAIT = 2'd2
    } sb_state_e;

endpackage

// File: rtl/store_drain_buffer_if.sv
// Bundle of the LSU commit, dmem store and forwarding-query signals of the
// store drain buffer; slave is the buffer, master is the surrounding LSU/dmem.
interface store_drain_buffer_if #(
    parameter int DEPTH = 8
);
    localparam int PTR_W = $clog2(DEPTH);

    logic           in_valid;
    logic           in_ready;
    logic [31:0]    in_addr;
    logic [63:0]    in_wdata;
    logic [7:0]     in_wstrb;

    logic           st_valid;
    logic           st_ready;
    logic [31:0]    st_addr;
    logic [63:0]    st_wdata;
    logic [7:0]     st_wstrb;
    logic           st_resp_valid;
    logic           st_resp_ready;

    logic [31:0]    fwd_addr;
    logic [7:0]     fwd_bytes;
    logic [63:0]    fwd_data;
    logic           fwd_hit;
    logic           fwd_conflict;

    logic           empty;
    logic [PTR_W:0] count;

    modport slave (
        input  in_valid, in_addr, in_wdata, in_wstrb,
        input  st_ready, st_resp_valid, fwd_addr, fwd_bytes,
        output in_ready, st_valid, st_addr, st_wdata, st_wstrb, st_resp_ready,
        output fwd_data, fwd_hit, fwd_conflict, empty, count
    );

    modport master (
        output in_valid, in_addr, in_wdata, in_wstrb,
        output st_ready, st_resp_valid, fwd_addr, fwd_bytes,
        input  in_ready, st_valid, st_addr, st_wdata, st_wstrb, st_resp_ready,
        input  fwd_data, fwd_hit, fwd_conflict, empty, count
    );

endinterface

// File: rtl/store_drain_buffer_fwd_merge.sv
// Byte-wise store-to-load forwarding: walks entries oldest to youngest from the
// head so that the youngest matching store wins each requested byte.
module sb_fwd_merge
    import lsu_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t        i_entries [DEPTH],
    input  logic [DEPTH-1:0] i_valid,
    input  logic [PTR_W-1:0] i_head,
    input  logic [31:3]      i_addr,
    input  logic [7:0]       i_bytes,
    output logic [63:0]      o_data,
    output logic             o_hit,
    output logic             o_conflict
);

    logic [7:0]       w_covered;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
        o_data    = '0;
        w_covered = '0;
        w_idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PTR_W'(k);
            if (i_valid[w_idx] && (i_entries[w_idx].addr == i_addr)) begin
                for (int b = 0; b < 8; b++) begin
                    if (i_bytes[b] && i_entries[w_idx].wstrb[b]) begin
                        o_data[8*b +: 8] = i_entries[w_idx].data[8*b +: 8];
                        w_covered[b]     = 1'b1;
                    end
                end
            end
        end
    end

    assign o_hit      = (i_bytes != 8'd0) && (w_covered == i_bytes);
    assign o_conflict = (w_covered != 8'd0) && (w_covered != i_bytes);

endmodule

// File: rtl/store_drain_buffer.sv
// In-order committed-store buffer: drains one store at a time to dmem, pops on
// store completion, and forwards buffered bytes to younger loads.
module store_drain_buffer
    import lsu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    store_drain_buffer_if.slave sb
);
    localparam int PTR_W = $clog2(DEPTH);

    sb_entry_t        r_entries [DEPTH];
    logic [PTR_W:0]   r_head;
    logic [PTR_W:0]   r_tail;
    sb_state_e        r_state;
    sb_state_e        w_state_nxt;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W:0]   w_count;
    logic [DEPTH-1:0] w_valid;
    sb_entry_t        w_head;
    logic             w_unused;

    assign w_count  = r_tail - r_head;
    assign w_empty  = (r_head == r_tail);
    assign w_full   = (r_head[PTR_W] != r_tail[PTR_W]) &&
                      (r_head[PTR_W-1:0] == r_tail[PTR_W-1:0]);
    assign w_push   = sb.in_valid && !w_full;
    assign w_pop    = (r_state == SB_WAIT) && sb.st_resp_valid;
    assign w_head   = r_entries[r_head[PTR_W-1:0]];
    assign w_unused = ^{sb.in_addr[2:0], sb.fwd_addr[2:0]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
        end
    end

    // NOTE: entry storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (rst_n && w_push)
            r_entries[r_tail[PTR_W-1:0]] <= '{addr:  sb.in_addr[31:3],
                                              data:  sb.in_wdata,
                                              wstrb: sb.in_wstrb};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= SB_IDLE;
        else        r_state <= w_state_nxt;
    end

    // A same-cycle push counts, so a store into an empty buffer issues next cycle.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            SB_IDLE: if (!w_empty || w_push) w_state_nxt = SB_REQ;
            SB_REQ:  if (sb.st_ready)        w_state_nxt = SB_WAIT;
            SB_WAIT: if (sb.st_resp_valid)
                         w_state_nxt = ((w_count > (PTR_W+1)'(1)) || w_push) ? SB_REQ : SB_IDLE;
            default: w_state_nxt = SB_IDLE;
        endcase
    end

    always_comb begin
        sb.st_valid      = 1'b0;
        sb.st_addr       = '0;
        sb.st_wdata      = '0;
        sb.st_wstrb      = '0;
        sb.st_resp_ready = 1'b0;
        case (r_state)
            SB_REQ: begin
                sb.st_valid = 1'b1;
                sb.st_addr  = {w_head.addr, 3'b000};
                sb.st_wdata = w_head.data;
                sb.st_wstrb = w_head.wstrb;
            end
            SB_WAIT: sb.st_resp_ready = 1'b1;
            default: ;
        endcase
    end

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < DEPTH; i++)
            w_valid[i] = {1'b0, PTR_W'(i) - r_head[PTR_W-1:0]} < w_count;
    end

    sb_fwd_merge #(.DEPTH(DEPTH)) u_fwd_merge (
        .i_entries  (r_entries),
        .i_valid    (w_valid),
        .i_head     (r_head[PTR_W-1:0]),
        .i_addr     (sb.fwd_addr[31:3]),
        .i_bytes    (sb.fwd_bytes),
        .o_data     (sb.fwd_data),
        .o_hit      (sb.fwd_hit),
        .o_conflict (sb.fwd_conflict)
    );

    assign sb.in_ready = !w_full;
    assign sb.empty    = w_empty;
    assign sb.count    = w_count;

endmodule
